spi_mem_arbiter: RTL and testbench
==================================

# spi_mem_arbiter

Two-port arbiter that shares the single `spi_memory_controller` CPU-side port between the CPU (port A) and a loader/DMA/debug master (port B). The arbiter sits between `cpu_top` and `spi_memory_controller`. It latches the winning request's address, write enable and write data, and holds `mem_req` until the controller's `mem_ready`. It routes read data and the ready pulse back to the granted requester only. Arbitration is round-robin, so both masters get a bounded worst-case wait.

## Interface
Parameters:
- `ADDR_W`, 16: address width (64 KB space).
- `DATA_W`, 16: read/write data width.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_req`  in  1  port A request; held high until `a_ready`.
- `a_we`  in  1  port A write enable (1 = write).
- `a_addr`  in  ADDR_W  port A address.
- `a_wdata`  in  DATA_W  port A write data.
- `a_rdata`  out  DATA_W  port A read data; valid while `a_ready`=1.
- `a_ready`  out  1  one-cycle completion pulse to port A.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_rdata`, `b_ready`: identical set for port B.
- `mem_req`  out  1  request to controller.
- `mem_we`  out  1  latched write enable.
- `mem_addr`  out  ADDR_W  latched address.
- `mem_wdata`  out  DATA_W  latched write data.
- `mem_rdata`  in  DATA_W  controller read data; valid with `mem_ready`.
- `mem_ready`  in  1  controller completion pulse (one cycle).
- `grant_b`  out  1  current/last grant owner (0 = A, 1 = B).
- `busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, XFER, RELEASE.
- IDLE: if neither requester is high, stay in IDLE.
  - Only `a_req`: grant A.
  - Only `b_req`: grant B.
  - Both: grant the port that is not `last_grant`.
  - On grant: latch the winner's `we`/`addr`/`wdata` into the `mem_*` registers, set `mem_req`=1, set `grant_b`, go to XFER.
- XFER: hold `mem_req` and the latched fields constant.
  - Changes on either requester's inputs are ignored.
  - On `mem_ready`=1, forward it combinationally to the granted port only: `x_ready`=1 and `x_rdata`=`mem_rdata`.
  - Clear `mem_req`, update `last_grant` to the owner, go to RELEASE.
- RELEASE: one cycle with `mem_req`=0, which lets the controller return to idle. Then go to IDLE.
- The non-granted port's `ready` stays 0 at all times. Both `rdata` outputs are 0 when their `ready` is 0.
- Requester contract: drop `req` or present a new transaction after seeing `ready`. A `req` still high in the next IDLE is treated as a new transaction.
- Writes: `mem_rdata` is still forwarded but is don't-care.
- Reset (`reset_n`=0, any state, including mid-XFER): immediately force
  - state = IDLE;
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `a_ready`=`b_ready`=0, `a_rdata`=`b_rdata`=0;
  - `grant_b`=0, `last_grant`=B (so A wins the first tie), `busy`=0.

  An in-flight transaction is abandoned and no ready is issued for it. The controller is reset by the same network.

## Timing
- Grant latency: a request sampled high in IDLE at edge N gives `mem_req`=1 and the latched fields valid after edge N.
- Completion: a `mem_ready` pulse in cycle M gives `x_ready` in the same cycle M (zero added latency). `mem_req`=0 from edge M.
- Back-to-back: next `mem_req` rises no earlier than two edges after `mem_ready` (RELEASE + IDLE). Minimum arbiter overhead is 2 cycles per transaction.
- Fairness: with both ports continuously requesting, grants strictly alternate. Worst-case wait for either port is one full transaction plus 2 cycles.
- A `mem_ready` arriving outside XFER is ignored; no `x_ready` is generated.
- `busy`=1 in XFER and RELEASE.

## Test plan
- Reset values: hold `reset_n`=0 with random inputs → all outputs 0. Release with `a_req`=`b_req`=1 → first grant A (`grant_b`=0).
- Single read A: `a_addr`=0x1234, `a_we`=0 → `mem_addr`=0x1234 one edge later. Controller model returns `mem_rdata`=0xBEEF after 40 cycles → `a_ready`=1 and `a_rdata`=0xBEEF in that cycle; `b_ready` stays 0.
- Write B with input churn: `b_we`=1, `b_addr`=0x00FF, `b_wdata`=0x00A5; change `b_addr` mid-XFER → `mem_addr` stays 0x00FF and `mem_wdata` stays 0x00A5 until `b_ready`.
- Contention: both ports request continuously for 6 transactions → grant order A,B,A,B,A,B. `mem_req` is low for exactly 2 edges between transactions.
- Reset mid-XFER: assert `reset_n`=0 while XFER(B) is outstanding → `mem_req`=0 and `busy`=0 immediately. A late `mem_ready` after release produces no `b_ready`.
- Full system: swap into `neander_tb_wrapper` with port A = CPU and port B = program loader. Load a program through B at 0x0000–0x000F, release the CPU → CPU executes and memory read-back matches.

Source files
------------

// File: rtl/spi_mem_arbiter_if.sv
// Bus bundle shared by the two requester ports (A, B) and the memory-controller port.
// The arbiter takes the slave view; the surrounding system or bench takes the master view.
interface spi_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_ready;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              grant_b;
    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_ready,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output grant_b, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_ready,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  grant_b, busy
    );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between requesters A and B.
// Latches the winner's transaction, holds mem_req until mem_ready, then one RELEASE cycle.
module spi_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    spi_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e            state_q,      state_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              grant_b_q,    grant_b_d;
    logic              last_grant_q, last_grant_d;
    logic              busy_q,       busy_d;
    logic              pick_b_s;
    logic              xfer_done_s;

    // State and latched-transaction registers; last_grant resets to B so A wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            grant_b_q    <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            grant_b_q    <= grant_b_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for mem_ready in XFER, one idle cycle in RELEASE.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        grant_b_d    = grant_b_q;
        last_grant_d = last_grant_q;
        pick_b_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    pick_b_s    = bus.b_req && (!bus.a_req || !last_grant_q);
                    grant_b_d   = pick_b_s;
                    mem_we_d    = pick_b_s ? bus.b_we    : bus.a_we;
                    mem_addr_d  = pick_b_s ? bus.b_addr  : bus.a_addr;
                    mem_wdata_d = pick_b_s ? bus.b_wdata : bus.a_wdata;
                    mem_req_d   = 1'b1;
                    state_d     = ST_XFER;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (bus.mem_ready) begin
                    mem_req_d    = 1'b0;
                    last_grant_d = grant_b_q;
                    state_d      = ST_RELEASE;
                end else begin
                    state_d      = ST_XFER;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Completion is forwarded in the same cycle, and only to the owner of the grant.
    assign xfer_done_s   = (state_q == ST_XFER) && bus.mem_ready;
    assign bus.a_ready   = xfer_done_s && !grant_b_q;
    assign bus.b_ready   = xfer_done_s &&  grant_b_q;
    assign bus.a_rdata   = bus.a_ready ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.b_rdata   = bus.b_ready ? bus.mem_rdata : {DATA_W{1'b0}};

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.grant_b   = grant_b_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: reset, single read, write with input churn,
// round-robin contention and reset during an outstanding transfer.
module tb_spi_mem_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    spi_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    spi_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ready_on(input logic [15:0] data);
        tick();
        bus.mem_rdata = data;
        bus.mem_ready = 1'b1;
        #1;
    endtask

    task automatic ready_off();
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        logic [15:0] exp_addr;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        bus.a_we = 1'($urandom); bus.b_we = 1'($urandom);
        bus.a_addr = 16'($urandom); bus.b_addr = 16'($urandom);
        bus.a_wdata = 16'($urandom); bus.b_wdata = 16'($urandom);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hFFFF;
        reset_n = 1'b0;
        repeat (3) tick();
        total++; if ({bus.mem_req, bus.mem_we, bus.grant_b, bus.busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {bus.mem_req, bus.mem_we, bus.grant_b, bus.busy}); end
        total++; if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
            bad++; $display("FAIL reset_mem_fields: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
        total++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b want 00", {bus.a_ready, bus.b_ready}); end
        total++; if ({bus.a_rdata, bus.b_rdata} !== 32'h0) begin
            bad++; $display("FAIL reset_rdata: got %h want 0", {bus.a_rdata, bus.b_rdata}); end
        bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0000;
        bus.a_addr = 16'h0A0A; bus.b_addr = 16'h0B0B; exp_addr = 16'h0A0A;
        reset_n = 1'b1;
        tick();
        total++; if (bus.grant_b !== 1'b0) begin
            bad++; $display("FAIL first_tie_grant: got %b want 0", bus.grant_b); end
        total++; if (bus.mem_req !== 1'b1 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL first_grant_req: got %b%b want 11", bus.mem_req, bus.busy); end
        total++; if (bus.mem_addr !== exp_addr) begin
            bad++; $display("FAIL first_grant_addr: got %h want %h", bus.mem_addr, exp_addr); end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        ready_on(16'h5555);
        total++; if (bus.a_ready !== 1'b1 || bus.a_rdata !== 16'h5555) begin
            bad++; $display("FAIL first_ready_a: got %b/%h want 1/5555", bus.a_ready, bus.a_rdata); end
        ready_off();
        tick();
    endtask

    task automatic test_single_read_a();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h1234; bus.a_wdata = 16'h0000;
        tick();
        total++; if (bus.mem_addr !== 16'h1234 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL read_a_latch: got %h/%b want 1234/0", bus.mem_addr, bus.mem_we); end
        total++; if (bus.mem_req !== 1'b1 || bus.grant_b !== 1'b0) begin
            bad++; $display("FAIL read_a_grant: got %b%b want 10", bus.mem_req, bus.grant_b); end
        repeat (38) tick();
        total++; if (bus.mem_req !== 1'b1 || bus.a_ready !== 1'b0) begin
            bad++; $display("FAIL read_a_hold: got %b%b want 10", bus.mem_req, bus.a_ready); end
        ready_on(16'hBEEF);
        total++; if (bus.a_ready !== 1'b1 || bus.a_rdata !== 16'hBEEF) begin
            bad++; $display("FAIL read_a_data: got %b/%h want 1/beef", bus.a_ready, bus.a_rdata); end
        total++; if (bus.b_ready !== 1'b0 || bus.b_rdata !== 16'h0000) begin
            bad++; $display("FAIL read_a_b_quiet: got %b/%h want 0/0000", bus.b_ready, bus.b_rdata); end
        bus.a_req = 1'b0;
        ready_off();
        total++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1 || bus.a_ready !== 1'b0 || bus.a_rdata !== 16'h0000) begin
            bad++; $display("FAIL read_a_release: got req=%b busy=%b rdy=%b rd=%h want 0 1 0 0000",
                            bus.mem_req, bus.busy, bus.a_ready, bus.a_rdata); end
        tick();
        total++; if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL read_a_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_write_b_churn();
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h00FF; bus.b_wdata = 16'h00A5;
        tick();
        total++; if (bus.grant_b !== 1'b1 || bus.mem_we !== 1'b1) begin
            bad++; $display("FAIL write_b_grant: got %b%b want 11", bus.grant_b, bus.mem_we); end
        bus.b_addr = 16'h1111; bus.b_wdata = 16'h2222; bus.b_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.mem_addr !== 16'h00FF || bus.mem_wdata !== 16'h00A5 || bus.mem_we !== 1'b1) begin
                bad++; $display("FAIL write_b_hold[%0d]: got %h/%h/%b want 00ff/00a5/1",
                                i, bus.mem_addr, bus.mem_wdata, bus.mem_we); end
        end
        ready_on(16'h3C3C);
        total++; if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0 || bus.a_rdata !== 16'h0000) begin
            bad++; $display("FAIL write_b_ready: got b=%b a=%b ard=%h want 1 0 0000",
                            bus.b_ready, bus.a_ready, bus.a_rdata); end
        bus.b_req = 1'b0;
        ready_off();
        tick();
    endtask

    task automatic test_contention();
        logic exp_b;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0AAA;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 16'h0BBB;
        for (int i = 0; i < 6; i++) begin
            exp_b = (i % 2) == 1;
            tick();
            total++; if (bus.mem_req !== 1'b1 || bus.grant_b !== exp_b) begin
                bad++; $display("FAIL contend_grant[%0d]: got req=%b gb=%b want 1 %b", i, bus.mem_req, bus.grant_b, exp_b); end
            total++; if (bus.mem_addr !== (exp_b ? 16'h0BBB : 16'h0AAA)) begin
                bad++; $display("FAIL contend_addr[%0d]: got %h want %h", i, bus.mem_addr, exp_b ? 16'h0BBB : 16'h0AAA); end
            repeat (2) tick();
            ready_on(16'(16'h0100 + i));
            total++; if ({bus.a_ready, bus.b_ready} !== (exp_b ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL contend_ready[%0d]: got %b want %b", i, {bus.a_ready, bus.b_ready}, exp_b ? 2'b01 : 2'b10); end
            ready_off();
            total++; if (bus.mem_req !== 1'b0) begin
                bad++; $display("FAIL contend_gap1[%0d]: got %b want 0", i, bus.mem_req); end
            tick();
            total++; if (bus.mem_req !== 1'b0) begin
                bad++; $display("FAIL contend_gap2[%0d]: got %b want 0", i, bus.mem_req); end
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
    endtask

    task automatic test_reset_mid_xfer();
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h4444; bus.b_wdata = 16'h9999;
        tick();
        total++; if (bus.grant_b !== 1'b1 || bus.mem_req !== 1'b1) begin
            bad++; $display("FAIL midrst_grant: got %b%b want 11", bus.grant_b, bus.mem_req); end
        tick();
        reset_n = 1'b0;
        #1;
        total++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.grant_b !== 1'b0) begin
            bad++; $display("FAIL midrst_force: got req=%b busy=%b gb=%b want 000", bus.mem_req, bus.busy, bus.grant_b); end
        total++; if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 16'h0000 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL midrst_fields: got %h/%h/%b want 0/0/0", bus.mem_addr, bus.mem_wdata, bus.mem_we); end
        bus.b_req = 1'b0;
        tick();
        reset_n = 1'b1;
        ready_on(16'h7777);
        total++; if ({bus.a_ready, bus.b_ready} !== 2'b00 || bus.b_rdata !== 16'h0000) begin
            bad++; $display("FAIL late_ready: got %b/%h want 00/0000", {bus.a_ready, bus.b_ready}, bus.b_rdata); end
        ready_off();
        total++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
            bad++; $display("FAIL late_ready_idle: got %b%b want 00", bus.busy, bus.mem_req); end
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        tick();
        total++; if (bus.grant_b !== 1'b0) begin
            bad++; $display("FAIL midrst_tie: got %b want 0", bus.grant_b); end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        ready_on(16'h1111);
        ready_off();
        tick();
    endtask

    initial begin
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 16'h0000; bus.a_wdata = 16'h0000;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 16'h0000; bus.b_wdata = 16'h0000;
        bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0000;
        test_reset();
        test_single_read_a();
        test_write_b_churn();
        test_contention();
        test_reset_mid_xfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
